hwt_vector_sequencer: RTL and testbench

//  Sequencing controller for the 4-input trojan-candidate logic cell (inputs A..D, output Y).
//  On start, it drives every 4-bit input vector onto the cell for NUM_PASSES passes.
//  It waits SETTLE_CYCLES, samples Y and compares it with the golden function Y = D & ((A & B) | C).
//  It reports mismatch count, first failing vector and a trojan flag. It sits between the bench/host and the cell under test.

---
 rtl/hwt_vector_sequencer.sv | 172 +++++++++++++++++
 tb/tb_hwt_vector_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwt_vector_sequencer.sv
// Sequencing controller for a 4-input logic cell (A..D -> Y).
// Sweeps all sixteen input vectors for a configurable number of passes,
// holds each vector for a settle window, samples the cell output and
// compares it against the golden function Y = D & ((A & B) | C).
// Reports a saturating mismatch count, the first failing vector and a
// trojan flag.
module hwt_vector_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_fail_vec,
    output logic             trojan_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_PASS   = 4'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_reg;
    logic [3:0]       vec_reg;
    logic [3:0]       pass_reg;
    logic [3:0]       settle_reg;
    logic [3:0]       dut_vec_reg;
    logic             dut_y_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [ERR_W-1:0] err_cnt_reg;
    logic [3:0]       first_fail_vec_reg;
    logic             trojan_flag_reg;

    logic             golden_y;
    logic             mismatch;

    // Expected cell response for the vector currently being exercised.
    assign golden_y = vec_reg[3] & ((vec_reg[0] & vec_reg[1]) | vec_reg[2]);
    assign mismatch = (dut_y_reg != golden_y);

    assign dut_a          = dut_vec_reg[0];
    assign dut_b          = dut_vec_reg[1];
    assign dut_c          = dut_vec_reg[2];
    assign dut_d          = dut_vec_reg[3];
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err_cnt        = err_cnt_reg;
    assign first_fail_vec = first_fail_vec_reg;
    assign trojan_flag    = trojan_flag_reg;

    // Capture the cell output so the comparison never sees a combinational path
    // through the cell; the value taken on the APPLY->SAMPLE edge is the one used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_y_reg <= 1'b0;
        end else begin
            dut_y_reg <= dut_y;
        end
    end

    // Main sequencer: state, sweep counters, cell drive and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            vec_reg            <= 4'd0;
            pass_reg           <= 4'd0;
            settle_reg         <= 4'd0;
            dut_vec_reg        <= 4'd0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            err_cnt_reg        <= '0;
            first_fail_vec_reg <= 4'd0;
            trojan_flag_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    dut_vec_reg <= 4'd0;
                    busy_reg    <= 1'b0;
                    if (start && !abort) begin
                        state_reg          <= APPLY;
                        busy_reg           <= 1'b1;
                        vec_reg            <= 4'd0;
                        pass_reg           <= 4'd0;
                        settle_reg         <= SETTLE_INIT;
                        dut_vec_reg        <= 4'd0;
                        err_cnt_reg        <= '0;
                        first_fail_vec_reg <= 4'd0;
                        trojan_flag_reg    <= 1'b0;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        dut_vec_reg <= 4'd0;
                    end else if (settle_reg != 4'd0) begin
                        settle_reg <= settle_reg - 4'd1;
                    end else begin
                        state_reg <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        // The sample taken in this cycle is dropped on abort.
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        dut_vec_reg <= 4'd0;
                    end else begin
                        if (mismatch) begin
                            if (err_cnt_reg != ERR_MAX) begin
                                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                            end
                            if (!trojan_flag_reg) begin
                                first_fail_vec_reg <= vec_reg;
                            end
                            trojan_flag_reg <= 1'b1;
                        end
                        if (vec_reg != 4'hF) begin
                            state_reg   <= APPLY;
                            vec_reg     <= vec_reg + 4'd1;
                            dut_vec_reg <= vec_reg + 4'd1;
                            settle_reg  <= SETTLE_INIT;
                        end else if (pass_reg != LAST_PASS) begin
                            state_reg   <= APPLY;
                            vec_reg     <= 4'd0;
                            dut_vec_reg <= 4'd0;
                            pass_reg    <= pass_reg + 4'd1;
                            settle_reg  <= SETTLE_INIT;
                        end else begin
                            state_reg   <= DONE;
                            dut_vec_reg <= 4'd0;
                            done_reg    <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    dut_vec_reg <= 4'd0;
                end

                default: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    dut_vec_reg <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwt_vector_sequencer.sv
// Self-checking bench for hwt_vector_sequencer. Three instances cover the
// default configuration, a two-pass sweep and a 2-bit saturating counter.
// Each run's expected results are pushed to a scoreboard when start is
// driven and popped when the instance reports done.
module tb_hwt_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  flag_v;
    logic [2:0]  y_v;
    logic [11:0] vec_all;
    logic [3:0]  ffv0, ffv1, ffv2;
    logic [7:0]  err0, err1;
    logic [1:0]  err2;
    int          mode_v [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    err;
        bit    flag;
        int    ffv;
        int    lat;
        string name;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    // Cell model: 0 golden, 1 stuck-at-0, 2 inverted only at 4'hF, 3 stuck-at-1.
    function automatic logic cell_y(input int md, input logic [3:0] v);
        logic g;
        g = v[3] & ((v[0] & v[1]) | v[2]);
        case (md)
            1:       return 1'b0;
            2:       return (v == 4'hF) ? ~g : g;
            3:       return 1'b1;
            default: return g;
        endcase
    endfunction

    assign y_v[0] = cell_y(mode_v[0], vec_all[3:0]);
    assign y_v[1] = cell_y(mode_v[1], vec_all[7:4]);
    assign y_v[2] = cell_y(mode_v[2], vec_all[11:8]);

    hwt_vector_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .dut_a(vec_all[0]), .dut_b(vec_all[1]), .dut_c(vec_all[2]), .dut_d(vec_all[3]),
        .dut_y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err_cnt(err0),
        .first_fail_vec(ffv0), .trojan_flag(flag_v[0])
    );

    hwt_vector_sequencer #(.NUM_PASSES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .dut_a(vec_all[4]), .dut_b(vec_all[5]), .dut_c(vec_all[6]), .dut_d(vec_all[7]),
        .dut_y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err_cnt(err1),
        .first_fail_vec(ffv1), .trojan_flag(flag_v[1])
    );

    hwt_vector_sequencer #(.ERR_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .dut_a(vec_all[8]), .dut_b(vec_all[9]), .dut_c(vec_all[10]), .dut_d(vec_all[11]),
        .dut_y(y_v[2]), .busy(busy_v[2]), .done(done_v[2]), .err_cnt(err2),
        .first_fail_vec(ffv2), .trojan_flag(flag_v[2])
    );

    function automatic int err_of(input int inst);
        case (inst)
            1:       return int'(err1);
            2:       return int'(err2);
            default: return int'(err0);
        endcase
    endfunction

    function automatic int ffv_of(input int inst);
        case (inst)
            1:       return int'(ffv1);
            2:       return int'(ffv2);
            default: return int'(ffv0);
        endcase
    endfunction

    function automatic int vec_of(input int inst);
        case (inst)
            1:       return int'(vec_all[7:4]);
            2:       return int'(vec_all[11:8]);
            default: return int'(vec_all[3:0]);
        endcase
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Full run on one instance: model the sweep, push, run, pop and compare.
    task automatic run_check(input string name, input int inst, input int md,
                             input int np, input int errw);
        exp_t e, r;
        int   cnt;
        int   emax;
        logic g, c;
        emax   = (1 << errw) - 1;
        e.err  = 0;
        e.flag = 1'b0;
        e.ffv  = 0;
        e.name = name;
        e.lat  = 16 * np * (2 + 1) + 1;
        for (int p = 0; p < np; p++) begin
            for (int v = 0; v < 16; v++) begin
                g = v[3] & ((v[0] & v[1]) | v[2]);
                c = cell_y(md, 4'(v));
                if (g != c) begin
                    if (!e.flag) e.ffv = v;
                    e.flag = 1'b1;
                    if (e.err < emax) e.err++;
                end
            end
        end
        mode_v[inst] = md;
        @(negedge clk);
        start_v[inst] = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start_v[inst] = 1'b0;
        cnt = 0;
        while (cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (done_v[inst]) break;
        end
        r = sb.pop_front();
        total++;
        if (done_v[inst] !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout: got=no_done expected=done_within_3000", r.name);
        end else begin
            check_int({r.name, "_latency"}, cnt, r.lat);
            check_int({r.name, "_err_cnt"}, err_of(inst), r.err);
            check_int({r.name, "_flag"}, int'(flag_v[inst]), int'(r.flag));
            if (r.flag) check_int({r.name, "_first_fail"}, ffv_of(inst), r.ffv);
            @(negedge clk);
            check_int({r.name, "_done_one_cycle"}, int'(done_v[inst]), 0);
            check_int({r.name, "_idle_busy"}, int'(busy_v[inst]), 0);
        end
        $display("run %s: inst=%0d cycles=%0d err=%0d flag=%0b ffv=%0h",
                 r.name, inst, cnt, err_of(inst), flag_v[inst], ffv_of(inst));
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_v = 3'b000;
        abort_v = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_busy", int'(busy_v), 0);
        check_int("reset_done", int'(done_v), 0);
        check_int("reset_flag", int'(flag_v), 0);
        check_int("reset_err0", err_of(0), 0);
        check_int("reset_ffv0", ffv_of(0), 0);
        check_int("reset_vectors", int'(vec_all), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: busy=%b done=%b vec=%h", busy_v, done_v, vec_all);
    endtask

    task automatic test_abort();
        int seen_done;
        mode_v[0] = 3;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        // Cycle 5 carries a start pulse that must be ignored; cycle 9 is the
        // SAMPLE of vector 2 and carries the abort, so that sample is dropped.
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start_v[0] = (c == 5);
            abort_v[0] = (c == 9);
        end
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        check_int("abort_busy", int'(busy_v[0]), 0);
        check_int("abort_vec", vec_of(0), 0);
        check_int("abort_err_partial", err_of(0), 2);
        check_int("abort_flag", int'(flag_v[0]), 1);
        check_int("abort_first_fail", ffv_of(0), 0);
        seen_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_v[0]) seen_done = 1;
        end
        check_int("abort_no_done", seen_done, 0);
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check_int("start_abort_idle_busy", int'(busy_v[0]), 0);
        check_int("start_abort_err_kept", err_of(0), 2);
        $display("abort: busy=%b err=%0d flag=%b", busy_v[0], err_of(0), flag_v[0]);
    endtask

    task automatic test_reset_midrun();
        mode_v[0] = 3;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_int("midrun_busy_before", int'(busy_v[0]), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_int("midrun_reset_busy", int'(busy_v[0]), 0);
        check_int("midrun_reset_err", err_of(0), 0);
        check_int("midrun_reset_flag", int'(flag_v[0]), 0);
        check_int("midrun_reset_vec", vec_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset_midrun: busy=%b err=%0d", busy_v[0], err_of(0));
    endtask

    task automatic test_back_to_back();
        run_check("b2b_stuck0", 0, 1, 1, 8);
        run_check("b2b_golden", 0, 0, 1, 8);
    endtask

    initial begin
        mode_v[0] = 0;
        mode_v[1] = 0;
        mode_v[2] = 0;
        test_reset();
        run_check("golden", 0, 0, 1, 8);
        run_check("stuck0", 0, 1, 1, 8);
        run_check("trojan_f", 0, 2, 1, 8);
        run_check("two_pass_stuck0", 1, 1, 2, 8);
        run_check("sat_stuck1", 2, 3, 1, 2);
        test_back_to_back();
        test_abort();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
